// File: rtl/io_pkg.sv
// Shared types and defaults for the processor-side I/O interrupt controller.
package io_pkg;
    localparam int W_DEF       = 16;
    localparam int NSRC_DEF    = 4;
    localparam int PULSE_DEF   = 1;
    localparam int TIMEOUT_DEF = 64;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        WAIT_ACK,
        GAP
    } state_t;
endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder over the eligible request vector.
module irq_prio_enc #(
    parameter int NSRC = 4,
    parameter int IW   = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] req,
    output logic            valid,
    output logic [IW-1:0]   id
);
    always_comb begin
        valid = |req;
        id    = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) id = IW'(i);
        end
    end
endmodule

// File: rtl/io_irq_controller.sv
// Collects peripheral interrupt requests, serves them one at a time to the
// core's interrupt/in_port pins, and captures the core's out_port writes.
module io_irq_controller
    import io_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int NSRC    = NSRC_DEF,
    parameter int PULSE   = PULSE_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    localparam int IW     = $clog2(NSRC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_req,
    input  logic [NSRC*W-1:0] irq_data,
    input  logic [NSRC-1:0] irq_mask,
    input  logic            irq_ack,
    input  logic            ovr_clr,
    input  logic            out_valid,
    input  logic [W-1:0]    out_port,
    output logic            interrupt,
    output logic [W-1:0]    in_port,
    output logic [IW-1:0]   irq_id,
    output logic [NSRC-1:0] overrun,
    output logic [W-1:0]    out_data,
    output logic            out_strobe
);
    logic [NSRC-1:0]  req_q;
    logic [NSRC-1:0]  pending;
    logic [NSRC-1:0]  edges;
    logic [NSRC-1:0]  ack_vec;
    logic [W-1:0]     data_q [NSRC];
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             sel_valid;
    logic [IW-1:0]    sel_id;
    logic             ack_ok;
    logic             load;

    assign edges     = irq_req & ~req_q;
    assign ack_ok    = irq_ack && (state == ASSERT || state == WAIT_ACK);
    assign interrupt = (state == ASSERT);

    irq_prio_enc #(.NSRC(NSRC), .IW(IW)) u_enc (
        .req   (pending & ~irq_mask),
        .valid (sel_valid),
        .id    (sel_id)
    );

    always_comb begin
        ack_vec = '0;
        if (ack_ok) ack_vec[irq_id] = 1'b1;
    end

    // A fresh edge on the source being acked re-arms it instead of overrunning.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= '0;
            pending <= '0;
            overrun <= '0;
            for (int i = 0; i < NSRC; i++) data_q[i] <= '0;
        end else begin
            req_q <= irq_req;
            for (int i = 0; i < NSRC; i++) begin
                if (edges[i] && (!pending[i] || ack_vec[i])) begin
                    pending[i] <= 1'b1;
                    data_q[i]  <= irq_data[i*W +: W];
                end else if (ack_vec[i]) begin
                    pending[i] <= 1'b0;
                end
                if (edges[i] && pending[i] && !ack_vec[i])
                    overrun[i] <= 1'b1;
                else if (ovr_clr)
                    overrun[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (sel_valid) begin
                    state_n = ASSERT;
                    cnt_n   = '0;
                    load    = 1'b1;
                end
            end
            ASSERT: begin
                if (ack_ok) begin
                    state_n = GAP;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(PULSE - 1)) begin
                    state_n = WAIT_ACK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_ACK: begin
                if (ack_ok) begin
                    state_n = GAP;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    state_n = ASSERT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            irq_id     <= '0;
            in_port    <= '0;
            out_data   <= '0;
            out_strobe <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            out_strobe <= out_valid;
            if (load) begin
                irq_id  <= sel_id;
                in_port <= data_q[sel_id];
            end
            if (out_valid) out_data <= out_port;
        end
    end
endmodule
